// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first, start/busy/done handshake.
// Define SERIAL_ADDER_OVERFLOW_EN to add the registered two's-complement overflow output v.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
`ifdef SERIAL_ADDER_OVERFLOW_EN
  output logic             v,
`endif
  output logic             c
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s_bit;
  logic             cy_nxt;
  logic [WIDTH-1:0] sum_shift;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             v_q, v_d;
`endif

  // One full-adder cell; the carry flop closes the loop bit to bit.
  assign s_bit     = a_sh_q[0] ^ b_sh_q[0] ^ cy_q;
  assign cy_nxt    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & cy_q) | (b_sh_q[0] & cy_q);
  assign sum_shift = {s_bit, sum_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    c_d     = c_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    v_d     = v_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          cy_d    = cin;
          sum_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        busy_d = 1'b1;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cy_d   = cy_nxt;
        sum_d  = sum_shift;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // cy_q is the carry into the MSB at this point, cy_nxt the carry out of it.
          y_d     = sum_shift;
          c_d     = cy_nxt;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          v_d     = cy_q ^ cy_nxt;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      v_q     <= v_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;
  assign c    = c_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign v    = v_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=8): directed cases plus random additions against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, c;
  logic [W-1:0] y;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         v;
`endif

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .y     (y),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .v     (v),
`endif
    .c     (c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one addition from IDLE (called #1 after an edge) and check the whole transaction.
  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    logic [W:0]   ref_sum;
    logic [W-1:0] y_before;
    logic         ref_v;
    int           edges;
    bit           seen;
    ref_sum  = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    ref_v    = (ta[W-1] == tb_[W-1]) && (ref_sum[W-1] != ta[W-1]);
    y_before = y;
    start = 1'b1; a = ta; b = tb_; cin = tc;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tc;
    check("busy_after_accept", busy, 1'b1);
    edges = 0;
    seen  = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      edges++;
      if (done) begin
        seen = 1;
        break;
      end
      check("busy_during_add", busy, 1'b1);
      check("y_held_during_add", y, y_before);
    end
    check("done_seen", seen, 1'b1);
    check("done_latency", edges, W);
    check("sum_y", y, ref_sum[W-1:0]);
    check("carry_c", c, ref_sum[W]);
    check("busy_in_done", busy, 1'b0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("overflow_v", v, ref_v);
`else
    if (ref_v) begin end
`endif
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    check("idle_not_busy", busy, 1'b0);
  endtask

  initial begin
    int       last_done;
    int       npulses;
    int       dones;
    logic [W-1:0] prev_y;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_y", y, '0);
    check("rst_c", c, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_add(8'h0F, 8'h01, 1'b0);
    do_add(8'hFF, 8'h01, 1'b0);
    do_add(8'hFF, 8'hFF, 1'b1);
    do_add(8'h7F, 8'h01, 1'b0);
    do_add(8'h80, 8'h80, 1'b0);

    // Start during busy must be ignored and must not queue.
    start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        check("ignore_y", y, 8'h07);
        check("ignore_c", c, 1'b0);
      end
    end
    check("ignore_one_done", dones, 1);
    check("ignore_idle", busy, 1'b0);

    // Asynchronous reset mid-addition aborts it.
    start = 1'b1; a = 8'h55; b = 8'h0F; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_y", y, '0);
    check("arst_c", c, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("arst_no_done", dones, 0);
    do_add(8'h01, 8'h01, 1'b0);

    // start held high: back-to-back additions every W+2 edges.
    prev_y = y;
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    last_done = -1;
    npulses = 0;
    for (int e = 1; e <= 3 * (W + 2) + 4; e++) begin
      @(posedge clk); #1;
      if (done) begin
        check("held_y", y, 8'h30);
        if (last_done >= 0) check("held_spacing", e - last_done, W + 2);
        last_done = e;
        npulses++;
        prev_y = y;
      end else if (busy) begin
        check("held_y_stable", y, prev_y);
      end
    end
    check("held_pulses", npulses, 3);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones = 1;
        break;
      end
    end
    check("held_drain", dones, 1);
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      do_add(W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
